// File: rtl/id_regfile_decode_pkg.sv
// ----------------------------------------------------------------------------
// id_regfile_decode_pkg
//   Constants shared by the register file, the field decoders and the
//   top-level wrapper: register count, register address width, default data
//   width and the one-hot widths of the 5-bit and 6-bit decoders.
// ----------------------------------------------------------------------------
package id_regfile_decode_pkg;

    localparam int REG_NUM        = 32;  // architectural registers
    localparam int REG_AW         = 5;   // register index width
    localparam int DATA_W_DEFAULT = 32;  // default register width
    localparam int ONEHOT5_W      = 32;  // one-hot width of a 5-bit field
    localparam int ONEHOT6_W      = 64;  // one-hot width of a 6-bit field

endpackage : id_regfile_decode_pkg

// File: rtl/id_regfile_decode_decoders.sv
// ----------------------------------------------------------------------------
// decoder_5_32 / decoder_6_64
//   Purely combinational binary-to-one-hot decoders for the register index
//   fields (rs, rt) and the instruction fields (opcode, func). Exactly one
//   output bit is set for every input value.
//
//   Ports (both modules):
//     code    in   5 / 6 bits   binary field value
//     onehot  out  32 / 64 bits onehot[i] = (code == i)
// ----------------------------------------------------------------------------
module decoder_5_32
    import id_regfile_decode_pkg::*;
(
    input  logic [REG_AW-1:0]    code,
    output logic [ONEHOT5_W-1:0] onehot
);

    assign onehot = ONEHOT5_W'(1) << code;

endmodule : decoder_5_32

module decoder_6_64
    import id_regfile_decode_pkg::*;
(
    input  logic [5:0]           code,
    output logic [ONEHOT6_W-1:0] onehot
);

    assign onehot = ONEHOT6_W'(1) << code;

endmodule : decoder_6_64

// File: rtl/id_regfile_decode_regfile.sv
// ----------------------------------------------------------------------------
// regfile
//   32 x DATA_W register file, one synchronous write port, two combinational
//   read ports. Register ZERO_REG is hardwired to zero: writes to it are
//   dropped and reads of it always return 0.
//
//   Optional feature (macro REGFILE_BYPASS_EN): a read port addressing the
//   register being written this cycle returns wdata directly (write-through).
//   Without the macro, reads return stored contents only, so the new value
//   becomes visible one cycle after the write.
//
//   Ports:
//     clk            in   1        rising-edge clock
//     rst            in   1        synchronous active-high reset, clears all
//     we             in   1        write enable
//     waddr / wdata  in   5 / W    write index / data
//     raddr1/raddr2  in   5        read indices
//     rdata1/rdata2  out  W        read data (zero-cycle latency)
// ----------------------------------------------------------------------------
module regfile
    import id_regfile_decode_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    logic [DATA_W-1:0] mem [REG_NUM];

    // NOTE: the array is cleared on reset because the architecture requires
    // all registers to read 0 afterwards; this forces flops rather than a RAM
    // macro, which is acceptable at 32 entries. Non-blocking assignments keep
    // every register update on the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != ZERO_IDX)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads of ZERO_IDX are masked as well, so the zero register holds even
    // before the first reset has cleared the array.
`ifdef REGFILE_BYPASS_EN
    logic wr_active;
    assign wr_active = we && !rst && (waddr != ZERO_IDX);

    assign rdata1 = (raddr1 == ZERO_IDX)              ? '0    :
                    (wr_active && (raddr1 == waddr))  ? wdata : mem[raddr1];
    assign rdata2 = (raddr2 == ZERO_IDX)              ? '0    :
                    (wr_active && (raddr2 == waddr))  ? wdata : mem[raddr2];
`else
    assign rdata1 = (raddr1 == ZERO_IDX) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == ZERO_IDX) ? '0 : mem[raddr2];
`endif

endmodule : regfile

// File: rtl/id_regfile_decode.sv
// ----------------------------------------------------------------------------
// id_regfile_decode
//   Instruction-decode slice: the general-purpose register file plus one-hot
//   decoders for opcode, func, rs (raddr1) and rt (raddr2). The decoders are
//   purely combinational and independent of rst and we.
//
//   Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
//   on the read ports (see regfile).
//
//   Ports:
//     clk, rst              in   1      clock, synchronous active-high reset
//     we, waddr, wdata      in   1/5/W  register write port
//     raddr1 / rdata1       in/out      read port 1 (rs field)
//     raddr2 / rdata2       in/out      read port 2 (rt field)
//     opcode, func          in   6      instruction bits [31:26] / [5:0]
//     op_d, func_d          out  64     one-hot opcode / func
//     rs_d, rt_d            out  32     one-hot raddr1 / raddr2
// ----------------------------------------------------------------------------
module id_regfile_decode
    import id_regfile_decode_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ZERO_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_AW-1:0]    raddr1,
    output logic [DATA_W-1:0]    rdata1,
    input  logic [REG_AW-1:0]    raddr2,
    output logic [DATA_W-1:0]    rdata2,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    output logic [ONEHOT6_W-1:0] op_d,
    output logic [ONEHOT6_W-1:0] func_d,
    output logic [ONEHOT5_W-1:0] rs_d,
    output logic [ONEHOT5_W-1:0] rt_d
);

    regfile #(
        .DATA_W   (DATA_W),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    decoder_6_64 u_op_dec   (.code(opcode), .onehot(op_d));
    decoder_6_64 u_func_dec (.code(func),   .onehot(func_d));
    decoder_5_32 u_rs_dec   (.code(raddr1), .onehot(rs_d));
    decoder_5_32 u_rt_dec   (.code(raddr2), .onehot(rt_d));

endmodule : id_regfile_decode

// File: tb/tb_id_regfile_decode.sv
// ----------------------------------------------------------------------------
// tb_id_regfile_decode
//   Self-checking bench for id_regfile_decode. A behavioural model (an array
//   of 32 words updated on every clock edge) predicts the read data; decoder
//   outputs are predicted by setting bit i for field value i.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_regfile_decode;

    localparam int DATA_W   = 32;
    localparam int ZERO_REG = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [4:0]        raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [63:0]       op_d;
    logic [63:0]       func_d;
    logic [31:0]       rs_d;
    logic [31:0]       rt_d;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] model [32];

    always #5 clk = ~clk;

    id_regfile_decode #(
        .DATA_W   (DATA_W),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .opcode (opcode),
        .func   (func),
        .op_d   (op_d),
        .func_d (func_d),
        .rs_d   (rs_d),
        .rt_d   (rt_d)
    );

    // Advance one rising edge, apply the architectural update rules to the
    // model, and leave inputs stable-able 1 ns after the edge.
    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && (waddr != ZERO_REG)) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    // Value a read port must show right now, given current inputs.
    function automatic logic [DATA_W-1:0] exp_read(input logic [4:0] addr);
        if (addr == ZERO_REG) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && (waddr == addr)) return wdata;
`endif
        return model[addr];
    endfunction

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; opcode = '0; func = '0;
        clock_edge();
        rst = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        tests++;
        if (rdata1 !== '0) begin
            fails++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1);
        end
        tests++;
        if (rdata2 !== '0) begin
            fails++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2);
        end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; raddr1 = 5'd3;
        #1;
        tests++;
        if (rdata1 !== exp_same) begin
            fails++; $display("FAIL write_cycle_read got=%h exp=%h", rdata1, exp_same);
        end
        clock_edge();
        we = 1'b0;
        #1;
        tests++;
        if (rdata1 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL write_next_read got=%h exp=deadbeef", rdata1);
        end
        raddr2 = 5'd3;
        #1;
        tests++;
        if (rdata2 !== rdata1 || rdata2 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL same_addr_both got=%h/%h exp=deadbeef", rdata1, rdata2);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        tests++;
        if (rdata1 !== '0) begin
            fails++; $display("FAIL zero_write_cycle got=%h exp=0", rdata1);
        end
        clock_edge();
        we = 1'b0;
        #1;
        tests++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            fails++; $display("FAIL zero_reg_read got=%h/%h exp=0/0", rdata1, rdata2);
        end
    endtask

    task automatic test_reset_priority();
        // Put a known value in r7 first, then collide write and reset.
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        clock_edge();
        we = 1'b1; rst = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        raddr1 = 5'd7; raddr2 = 5'd3;
        clock_edge();
        rst = 1'b0; we = 1'b0;
        #1;
        tests++;
        if (rdata1 !== '0) begin
            fails++; $display("FAIL reset_priority_r7 got=%h exp=0", rdata1);
        end
        tests++;
        if (rdata2 !== '0) begin
            fails++; $display("FAIL reset_clears_r3 got=%h exp=0", rdata2);
        end
    endtask

    task automatic test_decode();
        logic [63:0] e64;
        logic [31:0] e32;
        opcode = 6'b001101; func = 6'b100001; raddr1 = 5'd0; raddr2 = 5'd31;
        #1;
        tests++;
        if (op_d !== 64'h2000 || func_d !== 64'h0000_0002_0000_0000 ||
            rs_d !== 32'h1 || rt_d !== 32'h8000_0000) begin
            fails++;
            $display("FAIL decode_directed got op=%h func=%h rs=%h rt=%h", op_d, func_d, rs_d, rt_d);
        end
        // Sweep every field value while toggling rst/we randomly; decoders
        // must not care, and the model tracks any register side effects.
        for (int v = 0; v < 64; v++) begin
            opcode = v[5:0]; func = 6'(63 - v); raddr1 = v[4:0]; raddr2 = 5'(v + 7);
            rst = ($urandom_range(0, 3) == 0); we = $urandom_range(0, 1) == 1;
            waddr = 5'($urandom); wdata = $urandom;
            #1;
            e64 = '0; e64[opcode] = 1'b1;
            tests++;
            if (op_d !== e64 || $countones(op_d) != 1) begin
                fails++; $display("FAIL op_d v=%0d got=%h exp=%h", v, op_d, e64);
            end
            e64 = '0; e64[func] = 1'b1;
            tests++;
            if (func_d !== e64 || $countones(func_d) != 1) begin
                fails++; $display("FAIL func_d v=%0d got=%h exp=%h", v, func_d, e64);
            end
            e32 = '0; e32[raddr1] = 1'b1;
            tests++;
            if (rs_d !== e32 || $countones(rs_d) != 1) begin
                fails++; $display("FAIL rs_d v=%0d got=%h exp=%h", v, rs_d, e32);
            end
            e32 = '0; e32[raddr2] = 1'b1;
            tests++;
            if (rt_d !== e32 || $countones(rt_d) != 1) begin
                fails++; $display("FAIL rt_d v=%0d got=%h exp=%h", v, rt_d, e32);
            end
            clock_edge();
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we     = ($urandom_range(0, 3) != 0);
            waddr  = 5'($urandom_range(0, 7));   // small range forces collisions
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 7));
            #1;
            e1 = exp_read(raddr1);
            e2 = exp_read(raddr2);
            tests++;
            if (rdata1 !== e1) begin
                fails++; $display("FAIL rand_rdata1 n=%0d a=%0d got=%h exp=%h", n, raddr1, rdata1, e1);
            end
            tests++;
            if (rdata2 !== e2) begin
                fails++; $display("FAIL rand_rdata2 n=%0d a=%0d got=%h exp=%h", n, raddr2, rdata2, e2);
            end
            clock_edge();
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Fill every register on consecutive cycles, then read them all back.
        logic [DATA_W-1:0] e1, e2;
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = $urandom;
            clock_edge();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            e1 = exp_read(raddr1);
            e2 = exp_read(raddr2);
            tests++;
            if (rdata1 !== e1 || rdata2 !== e2) begin
                fails++;
                $display("FAIL b2b_read i=%0d got=%h/%h exp=%h/%h", i, rdata1, rdata2, e1, e2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_reset_priority();
        test_decode();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_id_regfile_decode
